tile_msg_sequencer: RTL and testbench

Host-side transmitter for the neuron tile message interface. It generates the `msgControl`/`msgData`/`msgVmem` sequence (reset, setup, weight stream, finished) that a `neuron_tile` consumes, fetching weight words from a synchronous weight memory. At the end of a run it captures the tile's spike and membrane-potential results. One instance drives one tile.

---
 rtl/tile_msg_sequencer_if.sv | 48 ++++
 rtl/tile_msg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_tile_msg_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tile_msg_sequencer_if.sv
// Message/memory/result bundle between a tile_msg_sequencer and its environment.
// master: the sequencer side (drives memory reads, tile messages, results).
// slave : the environment side (weight memory, neuron tile, host control).
//   start, vmemInit          host -> sequencer
//   memRdEn, memAddr         sequencer -> weight memory
//   memData                  weight memory -> sequencer (1 cycle after memRdEn)
//   tileReady, spikeIn,
//   vmemIn                   tile -> sequencer
//   msgControl, msgData,
//   msgVmem                  sequencer -> tile
//   busy, done, spikeOut,
//   vmemResult               sequencer -> host
interface tile_msg_sequencer_if #(
   parameter int size_data     = 8,
   parameter int size_vmem     = 16,
   parameter int size_tile     = 4,
   parameter int size_control  = 4,
   parameter int num_input     = 31,
   parameter int size_counters = $clog2(num_input)
);
   logic                           start;
   logic [size_vmem*size_tile-1:0] vmemInit;
   logic                           memRdEn;
   logic [size_counters-1:0]       memAddr;
   logic [size_data*size_tile-1:0] memData;
   logic                           tileReady;
   logic [size_control-1:0]        msgControl;
   logic [size_data*size_tile-1:0] msgData;
   logic [size_vmem*size_tile-1:0] msgVmem;
   logic                           spikeIn;
   logic [size_vmem*size_tile-1:0] vmemIn;
   logic                           busy;
   logic                           done;
   logic                           spikeOut;
   logic [size_vmem*size_tile-1:0] vmemResult;

   modport master (
      input  start, vmemInit, memData, tileReady, spikeIn, vmemIn,
      output memRdEn, memAddr, msgControl, msgData, msgVmem,
             busy, done, spikeOut, vmemResult
   );

   modport slave (
      output start, vmemInit, memData, tileReady, spikeIn, vmemIn,
      input  memRdEn, memAddr, msgControl, msgData, msgVmem,
             busy, done, spikeOut, vmemResult
   );
endinterface

// File: rtl/tile_msg_sequencer.sv
// Host-side transmitter for one neuron tile. Sends RESET, SETUP, a stream of
// num_input weight words fetched from a synchronous weight memory, then
// FINISHED for finish_cycles cycles, and captures the tile's spike/Vmem result.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - tile_msg_sequencer_if.master (memory, tile message and result signals)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// st_idle   | waiting for start, msgControl=STOP
// st_reset  | one cycle of RESET, loads msgVmem from vmemInit
// st_setup  | one cycle of SETUP, clears the issue counter
// st_stream | DATA; issues reads while tileReady and words remain
// st_finish | FINISHED for finish_cycles cycles, captures results on last
// st_done   | pulses done, returns to idle
module tile_msg_sequencer #(
   parameter int size_data     = 8,
   parameter int size_vmem     = 16,
   parameter int size_tile     = 4,
   parameter int size_control  = 4,
   parameter int num_input     = 31,
   parameter int size_counters = $clog2(num_input),
   parameter int finish_cycles = 3
) (
   input logic                   clk,
   input logic                   rst,
   tile_msg_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      st_idle,
      st_reset,
      st_setup,
      st_stream,
      st_finish,
      st_done
   } state_t;

   localparam logic [size_control-1:0] ctl_stop     = size_control'(0);
   localparam logic [size_control-1:0] ctl_reset    = size_control'(1);
   localparam logic [size_control-1:0] ctl_setup    = size_control'(2);
   localparam logic [size_control-1:0] ctl_data     = size_control'(6);
   localparam logic [size_control-1:0] ctl_finished = size_control'(8);

   localparam int fin_w = (finish_cycles > 1) ? $clog2(finish_cycles) : 1;
   // One extra bit so that num_input == 2**size_counters is representable.
   localparam logic [size_counters:0] num_k = (size_counters + 1)'(num_input);
   localparam logic [fin_w-1:0]       fin_load = fin_w'(finish_cycles - 1);

   state_t                         state, state_nxt;
   logic [size_counters:0]         k_cnt, k_nxt;
   logic [fin_w-1:0]               fin_cnt, fin_nxt;
   logic [size_control-1:0]        ctl_q, ctl_nxt;
   logic                           rd_en_q, rd_en_nxt;
   logic [size_counters-1:0]       addr_q, addr_nxt;
   logic [size_vmem*size_tile-1:0] vmem_q, vmem_nxt;
   logic                           busy_q, busy_nxt;
   logic                           done_q, done_nxt;
   logic                           capture;
   logic                           rd_valid;
   logic                           spike_q;
   logic [size_vmem*size_tile-1:0] result_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= st_idle;
         k_cnt    <= '0;
         fin_cnt  <= '0;
         ctl_q    <= ctl_stop;
         rd_en_q  <= 1'b0;
         addr_q   <= '0;
         vmem_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rd_valid <= 1'b0;
         spike_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state    <= state_nxt;
         k_cnt    <= k_nxt;
         fin_cnt  <= fin_nxt;
         ctl_q    <= ctl_nxt;
         rd_en_q  <= rd_en_nxt;
         addr_q   <= addr_nxt;
         vmem_q   <= vmem_nxt;
         busy_q   <= busy_nxt;
         done_q   <= done_nxt;
         rd_valid <= rd_en_q;
         if (capture) begin
            spike_q  <= bus.spikeIn;
            result_q <= bus.vmemIn;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      k_nxt     = k_cnt;
      fin_nxt   = fin_cnt;
      ctl_nxt   = ctl_stop;
      rd_en_nxt = 1'b0;
      addr_nxt  = addr_q;
      vmem_nxt  = vmem_q;
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
      capture   = 1'b0;
      case (state)
         st_idle: begin
            busy_nxt = 1'b0;
            if (bus.start) state_nxt = st_reset;
         end
         st_reset: begin
            ctl_nxt   = ctl_reset;
            vmem_nxt  = bus.vmemInit;
            state_nxt = st_setup;
         end
         st_setup: begin
            ctl_nxt   = ctl_setup;
            k_nxt     = '0;
            state_nxt = st_stream;
         end
         st_stream: begin
            ctl_nxt = ctl_data;
            if (bus.tileReady && (k_cnt < num_k)) begin
               rd_en_nxt = 1'b1;
               addr_nxt  = k_cnt[size_counters-1:0];
               k_nxt     = k_cnt + 1'b1;
            end
            // The last read is in flight; DATA stays up one more cycle while
            // that word is presented, then FINISHED follows.
            if ((k_cnt == num_k) && rd_en_q) begin
               state_nxt = st_finish;
               fin_nxt   = fin_load;
            end
         end
         st_finish: begin
            ctl_nxt = ctl_finished;
            if (fin_cnt == '0) begin
               capture   = 1'b1;
               state_nxt = st_done;
            end else begin
               fin_nxt = fin_cnt - 1'b1;
            end
         end
         st_done: begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = st_idle;
         end
         default: state_nxt = st_idle;
      endcase
   end

   // The memory's output register is the pipeline stage for weight words, so
   // the word is forwarded in the cycle it arrives and zeroed otherwise.
   assign bus.msgData    = rd_valid ? bus.memData : '0;
   assign bus.memRdEn    = rd_en_q;
   assign bus.memAddr    = addr_q;
   assign bus.msgControl = ctl_q;
   assign bus.msgVmem    = vmem_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.spikeOut   = spike_q;
   assign bus.vmemResult = result_q;

endmodule

// File: tb/tb_tile_msg_sequencer.sv
module tb_tile_msg_sequencer;

   localparam int n1 = 31;
   localparam logic [3:0] c_stop = 4'b0000;
   localparam logic [3:0] c_rst  = 4'b0001;
   localparam logic [3:0] c_set  = 4'b0010;
   localparam logic [3:0] c_dat  = 4'b0110;
   localparam logic [3:0] c_fin  = 4'b1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   tile_msg_sequencer_if #(.num_input(31)) bus ();
   tile_msg_sequencer_if #(.num_input(32)) bus2 ();

   tile_msg_sequencer #(.num_input(31)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   tile_msg_sequencer #(.num_input(32)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.master)
   );

   // synchronous weight memories: word k = {4{k[7:0]}}
   always @(posedge clk) if (bus.memRdEn)  bus.memData  <= {4{8'(bus.memAddr)}};
   always @(posedge clk) if (bus2.memRdEn) bus2.memData <= {4{8'(bus2.memAddr)}};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Nominal-timeline cycle for cycle c, with a tileReady stall of len cycles
   // starting at cycle 10 (stall cycles map onto a DATA cycle).
   function automatic int eff(input int c, input int len);
      if (c < 10) return c;
      if (c < 10 + len) return 10;
      return c - len;
   endfunction

   // Address issued in cycle c, or -1.
   function automatic int issue_of(input int c, input int len);
      int e;
      if (c >= 10 && c < 10 + len) return -1;
      e = eff(c, len);
      if (e >= 3 && e <= n1 + 2) return e - 3;
      return -1;
   endfunction

   function automatic logic [3:0] ctl_of(input int e);
      if (e == 1) return c_rst;
      if (e == 2) return c_set;
      if (e >= 3 && e <= n1 + 3) return c_dat;
      if (e >= n1 + 4 && e <= n1 + 6) return c_fin;
      return c_stop;
   endfunction

   task automatic run_main(input int len, input bit hold_mid, input logic [63:0] vinit, input string nm);
      int e, a, w, cap;
      cap = n1 + 6 + len;
      bus.vmemInit  = vinit;
      bus.start     = 1'b1;
      bus.tileReady = 1'b1;
      bus.vmemIn    = '0;
      bus.spikeIn   = 1'b0;
      for (int c = 0; c <= n1 + 10 + len; c++) begin
         tick();
         e = eff(c, len);
         a = issue_of(c, len);
         w = issue_of(c - 1, len);
         chk($sformatf("%s ctl@%0d", nm, c), 64'(bus.msgControl), 64'(ctl_of(e)));
         chk($sformatf("%s rden@%0d", nm, c), 64'(bus.memRdEn), 64'(a >= 0));
         if (a >= 0) chk($sformatf("%s addr@%0d", nm, c), 64'(bus.memAddr), 64'(a));
         chk($sformatf("%s data@%0d", nm, c), 64'(bus.msgData), (w >= 0) ? 64'({4{8'(w)}}) : 64'd0);
         chk($sformatf("%s busy@%0d", nm, c), 64'(bus.busy), 64'(e >= 1 && e <= n1 + 6));
         chk($sformatf("%s done@%0d", nm, c), 64'(bus.done), 64'(e == n1 + 7));
         if (c >= 1) chk($sformatf("%s vmem@%0d", nm, c), bus.msgVmem, vinit);
         if (e == n1 + 7) begin
            chk($sformatf("%s spike", nm), 64'(bus.spikeOut), 64'(cap % 2));
            chk($sformatf("%s result", nm), bus.vmemResult, {4{16'(cap)}});
         end
         bus.start     = hold_mid && (c + 1 >= 15) && (c + 1 <= 41);
         bus.tileReady = !((c + 1 >= 10) && (c + 1 < 10 + len));
         bus.vmemIn    = {4{16'(c + 1)}};
         bus.spikeIn   = 1'((c + 1) % 2);
      end
   endtask

   initial begin
      int cnt, nexp;
      bus.start = 1'b0;  bus.vmemInit = '0;  bus.tileReady = 1'b1;
      bus.spikeIn = 1'b0; bus.vmemIn = '0;   bus.memData = '0;
      bus2.start = 1'b0; bus2.vmemInit = 64'h0001_0002_0003_0004; bus2.tileReady = 1'b1;
      bus2.spikeIn = 1'b0; bus2.vmemIn = '0; bus2.memData = '0;
      tick();
      tick();
      chk("rst ctl",    64'(bus.msgControl), 64'(c_stop));
      chk("rst data",   64'(bus.msgData), 64'd0);
      chk("rst vmem",   bus.msgVmem, 64'd0);
      chk("rst busy",   64'(bus.busy), 64'd0);
      chk("rst rden",   64'(bus.memRdEn), 64'd0);
      chk("rst result", bus.vmemResult, 64'd0);
      rst = 1'b0;
      tick();

      run_main(0, 1'b0, 64'h0001_0002_0003_0004, "nom");
      run_main(3, 1'b1, 64'h1111_2222_3333_4444, "bp");

      // asynchronous abort in cycle 20
      bus.vmemInit = 64'h0005_0006_0007_0008;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c <= 20; c++) tick();
      chk("abort busy before", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("abort ctl",    64'(bus.msgControl), 64'(c_stop));
      chk("abort data",   64'(bus.msgData), 64'd0);
      chk("abort rden",   64'(bus.memRdEn), 64'd0);
      chk("abort addr",   64'(bus.memAddr), 64'd0);
      chk("abort vmem",   bus.msgVmem, 64'd0);
      chk("abort busy",   64'(bus.busy), 64'd0);
      chk("abort result", bus.vmemResult, 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("abort done@%0d", c), 64'(bus.done), 64'd0);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("post abort ctl@%0d", c), 64'(bus.msgControl), 64'(c_stop));
         chk($sformatf("post abort done@%0d", c), 64'(bus.done), 64'd0);
      end
      run_main(0, 1'b0, 64'h0009_000a_000b_000c, "rerun");

      // start held high across done: restart from the IDLE cycle after done
      bus.start = 1'b1;
      for (int c = 0; c <= 77; c++) begin
         tick();
         chk($sformatf("hold done@%0d", c), 64'(bus.done), 64'(c == 38 || c == 77));
         chk($sformatf("hold rstctl@%0d", c), 64'(bus.msgControl == c_rst), 64'(c == 1 || c == 40));
      end
      bus.start = 1'b0;
      for (int c = 0; c < 4; c++) tick();

      // num_input = 32: full address space, no wrap
      cnt = 0;
      nexp = 0;
      bus2.start = 1'b1;
      for (int c = 0; c <= 42; c++) begin
         tick();
         bus2.start = 1'b0;
         chk($sformatf("n32 rden@%0d", c), 64'(bus2.memRdEn), 64'(c >= 3 && c <= 34));
         if (bus2.memRdEn) begin
            chk($sformatf("n32 addr@%0d", c), 64'(bus2.memAddr), 64'(nexp));
            nexp++;
            cnt++;
         end
         chk($sformatf("n32 done@%0d", c), 64'(bus2.done), 64'(c == 39));
         if (c == 35) chk("n32 last word", 64'(bus2.msgData), 64'({4{8'd31}}));
      end
      chk("n32 issue count", 64'(cnt), 64'd32);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
